mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, max consecutive grants to one master while the other master is requesting (range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req / m1_req  input  1 each  master requests a bus cycle this clock.
REQ-005 m0_addr / m1_addr  input  32 each  byte address of the request.
REQ-006 m0_wdata / m1_wdata  input  32 each  write data.
REQ-007 m0_wmask / m1_wmask  input  4 each  byte write enables; 4'h0 marks a read.
REQ-008 m0_lock / m1_lock  input  1 each  owner asks to keep the bus for its next cycle.
REQ-009 m0_gnt / m1_gnt  output  1 each  request accepted this cycle (combinational).
REQ-010 m0_rvalid / m1_rvalid  output  1 each  read data valid (registered).
REQ-011 m0_rdata / m1_rdata  output  32 each  read data; 32'h0 when the matching rvalid is low.
REQ-012 bus_addr, bus_wdata, bus_wmask  output  32/32/4  downstream cycle for the granted master.
REQ-013 bus_rdata  input  32  downstream read data, valid one cycle after the address cycle.
REQ-014 bus_owner  output  1  index of the master granted this cycle; 0 when idle.

Function
REQ-015 The arbiter SHALL assert at most one gnt per cycle, and only to a master whose req is high.
REQ-016 With exactly one req high, the arbiter SHALL grant that master in the same cycle, regardless of lock or hold count.
REQ-017 With both reqs high, the arbiter SHALL grant the previous owner if its lock was high on its last granted cycle and hold_cnt < MAX_HOLD; otherwise it SHALL grant the master not in last_gnt.
REQ-018 last_gnt (1 bit) SHALL update to the granted index on every granted cycle and hold its value on idle cycles.
REQ-019 lock_q SHALL capture the granted master's lock on each granted cycle and clear on idle cycles.
REQ-020 hold_cnt (8 bit) SHALL increment, saturating at 255, when the same master is granted again while the other master requests; it SHALL load 1 when ownership changes or when the other master is idle.
REQ-021 When hold_cnt reaches MAX_HOLD and the other master requests, the next grant SHALL go to the other master even if lock is high.
REQ-022 bus_addr/bus_wdata/bus_wmask SHALL mirror the granted master combinationally; with no grant they SHALL be 0, so no write can occur.
REQ-023 A granted read SHALL raise that master's rvalid for exactly the following cycle, with mX_rdata = bus_rdata in that cycle; a granted write SHALL produce no rvalid.
REQ-024 Back-to-back reads SHALL be supported: a grant in cycle N+1 and an rvalid for cycle N's read in cycle N+1 SHALL coexist, with each rvalid routed to its own master.
REQ-025 A master not granted SHALL see gnt low; it SHALL hold req, addr, wdata, wmask and lock stable until granted; the arbiter SHALL keep no queued request.
REQ-026 Latency: uncontended grant SHALL be 0 cycles and read data 1 cycle; worst-case wait under contention SHALL be MAX_HOLD cycles.

Reset
REQ-027 While reset is high, gnt, rvalid, rdata, bus_* and bus_owner SHALL all be 0, independent of req.
REQ-028 On reset, last_gnt SHALL become 1 (m0 wins the first contended cycle), lock_q SHALL become 0 and hold_cnt SHALL become 0.
REQ-029 A read granted in the cycle that reset is asserted SHALL NOT produce rvalid after reset deasserts.
REQ-030 Arbitration SHALL resume in the first cycle with reset low.

Verification
REQ-031 After reset, m0 and m1 both read (m0 0xF0000000, m1 0xF0000010) -> m0_gnt in cycle 0, m1_gnt in cycle 1, m0_rvalid in cycle 1, m1_rvalid in cycle 2, each rdata equal to bus_rdata of its cycle.
REQ-032 m1 alone writes 0x10000000, wmask 4'h1, wdata 0xA5 -> m1_gnt=1, bus_owner=1, bus_wmask=4'h1 in the same cycle, and no rvalid follows.
REQ-033 MAX_HOLD=4; m0 requests with lock=1 for 10 cycles, m1 requests from cycle 0 -> m0 granted in cycles 0-3, m1 in cycle 4, m0 in cycle 5.
REQ-034 Both masters request continuously with lock=0 -> grants strictly alternate m0,m1,m0,... and no two gnts are ever high together.
REQ-035 m0 read granted at cycle 5 with reset high at cycle 5 -> m0_rvalid=0 at cycle 6, all bus_* = 0 during reset, and m0 wins the first contended cycle after release.
REQ-036 No req for 3 cycles, then m1 requests -> bus_* = 0 while idle, and m1 is granted immediately even though last_gnt=1.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master bus arbiter with lock/hold fairness and a one-cycle read-return path.
// Grants and the downstream bus are combinational; read valids are registered.
module mem_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_lock,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic [31:0] bus_rdata,
    output logic        bus_owner
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic       last_gnt;
    logic       lock_q;
    logic [7:0] hold_cnt;
    logic [1:0] rvalid_q;

    logic gnt0;
    logic gnt1;
    logic granted;
    logic other_req;
    logic owner_lock;

    // Lock only extends ownership while the hold budget lasts; otherwise rotate.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (lock_q && (hold_cnt < HOLD_LIMIT)) begin
                    gnt0 = ~last_gnt;
                    gnt1 = last_gnt;
                end else begin
                    gnt0 = last_gnt;
                    gnt1 = ~last_gnt;
                end
            end
        end
    end

    assign granted    = gnt0 | gnt1;
    assign other_req  = gnt1 ? m0_req  : m1_req;
    assign owner_lock = gnt1 ? m1_lock : m0_lock;

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign bus_owner = gnt1;

    always_comb begin
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_wmask = 4'h0;
        if (gnt0) begin
            bus_addr  = m0_addr;
            bus_wdata = m0_wdata;
            bus_wmask = m0_wmask;
        end else if (gnt1) begin
            bus_addr  = m1_addr;
            bus_wdata = m1_wdata;
            bus_wmask = m1_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b1;
            lock_q   <= 1'b0;
            hold_cnt <= 8'h0;
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= {gnt1 && (m1_wmask == 4'h0), gnt0 && (m0_wmask == 4'h0)};
            if (granted) begin
                last_gnt <= gnt1;
                lock_q   <= owner_lock;
                if ((gnt1 == last_gnt) && other_req) begin
                    if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end else begin
                    hold_cnt <= 8'd1;
                end
            end else begin
                lock_q <= 1'b0;
            end
        end
    end

    // Read-return is masked during reset so a stale valid never leaks out.
    assign m0_rvalid = rvalid_q[0] & ~reset;
    assign m1_rvalid = rvalid_q[1] & ~reset;
    assign m0_rdata  = m0_rvalid ? bus_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? bus_rdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed per-cycle vectors push expected
// grants and read returns; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_rdata = '0;
    logic        bus_owner;

    mem_bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_lock(m0_lock),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rdata(bus_rdata), .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    function automatic logic [31:0] pat(input int c);
        return 32'h5A00_0000 + 32'(c);
    endfunction

    function automatic logic [31:0] wd(input logic [31:0] a);
        return 32'hA5 ^ {24'h0, a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // exp: 0 = no grant, 1 = m0, 2 = m1
    task automatic step(input logic rst,
                        input logic r0, input logic [31:0] a0, input logic [3:0] k0, input logic l0,
                        input logic r1, input logic [31:0] a1, input logic [3:0] k1, input logic l1,
                        input int exp);
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        m0_req = r0; m0_addr = a0; m0_wdata = wd(a0); m0_wmask = k0; m0_lock = l0;
        m1_req = r1; m1_addr = a1; m1_wdata = wd(a1); m1_wmask = k1; m1_lock = l1;
        bus_rdata = pat(cyc);
        if (exp != 0) begin
            g.cyc = cyc;
            g.m = (exp == 2);
            g.addr = g.m ? a1 : a0;
            g.wdata = wd(g.addr);
            g.wmask = g.m ? k1 : k0;
            gq.push_back(g);
            if (g.wmask == 4'h0) begin
                r.cyc = cyc + 1;
                r.m = g.m;
                r.data = pat(cyc + 1);
                rq.push_back(r);
            end
        end
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (reset) begin
                chk("reset_outputs",
                    64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_owner, bus_wmask}), 64'h0);
                chk("reset_bus", 64'({bus_addr, bus_wdata}), 64'h0);
                chk("reset_rdata", 64'({m0_rdata, m1_rdata}), 64'h0);
            end else begin
                chk("one_hot_gnt", 64'(m0_gnt & m1_gnt), 64'h0);
                if (m0_gnt || m1_gnt) begin
                    if (gq.size() == 0 || gq[0].cyc != cyc) begin
                        chk("unexpected_gnt", 64'({m1_gnt, m0_gnt}), 64'h0);
                    end else begin
                        gexp_t e;
                        e = gq.pop_front();
                        chk("gnt", 64'({m1_gnt, m0_gnt}), e.m ? 64'h2 : 64'h1);
                        chk("bus_owner", 64'(bus_owner), 64'(e.m));
                        chk("bus_addr", 64'(bus_addr), 64'(e.addr));
                        chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
                        chk("bus_wmask", 64'(bus_wmask), 64'(e.wmask));
                    end
                end else begin
                    chk("idle_bus", 64'({bus_owner, bus_wmask, bus_addr}), 64'h0);
                    chk("idle_wdata", 64'(bus_wdata), 64'h0);
                    if (gq.size() != 0 && gq[0].cyc == cyc) begin
                        chk("missing_gnt", 64'h0, gq[0].m ? 64'h2 : 64'h1);
                        void'(gq.pop_front());
                    end
                end
                if (m0_rvalid || m1_rvalid) begin
                    if (rq.size() == 0 || rq[0].cyc != cyc) begin
                        chk("unexpected_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'h0);
                    end else begin
                        rexp_t e;
                        e = rq.pop_front();
                        chk("rvalid", 64'({m1_rvalid, m0_rvalid}), e.m ? 64'h2 : 64'h1);
                        chk("rdata", 64'(e.m ? m1_rdata : m0_rdata), 64'(e.data));
                        chk("rdata_other", 64'(e.m ? m0_rdata : m1_rdata), 64'h0);
                    end
                end else begin
                    chk("rdata_idle", 64'({m0_rdata, m1_rdata}), 64'h0);
                    if (rq.size() != 0 && rq[0].cyc == cyc) begin
                        chk("missing_rvalid", 64'h0, rq[0].m ? 64'h2 : 64'h1);
                        void'(rq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        idle(1'b1);
        idle(1'b1);

        // Both read after reset: m0 first (last_gnt resets to 1), then m1.
        step(0, 1, 32'hF000_0000, 4'h0, 0, 1, 32'hF000_0010, 4'h0, 0, 1);
        step(0, 0, 32'h0, 4'h0, 0, 1, 32'hF000_0010, 4'h0, 0, 2);

        // m1 alone writes; no read return may follow.
        step(0, 0, 32'h0, 4'h0, 0, 1, 32'h1000_0000, 4'h1, 0, 2);

        // Idle gap, then m1 alone is granted at once despite last_gnt=1.
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        step(0, 0, 32'h0, 4'h0, 0, 1, 32'h2000_0004, 4'h0, 0, 2);

        // m0 locks against a constantly requesting m1; hold limit is 4.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h3000_0000 + 32'(i * 4), 4'h0, 1,
                    1, 32'h3100_0000, 4'h0, 0, (i == 4 || i == 9) ? 2 : 1);
        end

        // Unlocked contention alternates; the last grant (a write) goes to m0.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h3800_0000 + 32'(i * 4), (i == 4) ? 4'hF : 4'h0, 0,
                    1, 32'h3900_0000 + 32'(i * 4), 4'h3, 0, (i % 2 == 1) ? 2 : 1);
        end

        // Reset with both requesting: no grant, then m0 wins again after release.
        step(1, 1, 32'h4000_0000, 4'h0, 0, 1, 32'h4100_0000, 4'h0, 0, 0);
        step(0, 1, 32'h4000_0000, 4'h0, 0, 1, 32'h4100_0000, 4'h0, 0, 1);
        step(0, 0, 32'h0, 4'h0, 0, 1, 32'h4100_0000, 4'h0, 0, 2);

        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        #1;
        chk("grants_left", 64'(gq.size()), 64'h0);
        chk("rvalids_left", 64'(rq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
